// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width and Gray/binary helpers shared by FIFO read and write controllers
package fifo_pkg;
    localparam int DEEP_DEF = 8;
    localparam int FN_W = 32;
    function automatic int ptr_width(input int deep);
        return deep + 1;
    endfunction
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if: memory-side and downstream signals of the FIFO read controller
interface fifo_read_ctrl_if import fifo_pkg::*; #(
    parameter int N = 8,
    parameter int DEEP = DEEP_DEF
);
    logic [DEEP:0] address_w, address_r, level;
    logic [N-1:0] data_o, dout;
    logic r_en, dout_valid, dout_ready, empty;
    modport master(input address_w, data_o, dout_ready, output r_en, address_r, dout, dout_valid, empty, level);
    modport slave(output address_w, data_o, dout_ready, input r_en, address_r, dout, dout_valid, empty, level);
endinterface

// File: rtl/fifo_read_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing a Gray pointer into the clk_out domain
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_out,
    input  logic         arst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk_out)
        if (arst) {q, meta} <= '0;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side FIFO controller with a two-word output buffer
module fifo_read_ctrl import fifo_pkg::*; #(
    parameter int N = 8,
    parameter int DEEP = DEEP_DEF
) (
    input logic clk_out,
    input logic arst,
    fifo_read_ctrl_if.master bus
);
    localparam int PW = ptr_width(DEEP);
    logic [DEEP:0] wsync, rbin, rbin_nxt;
    logic [N-1:0] buf0, buf1;
    logic [1:0] count, c1;
    logic [2:0] occ;
    logic pend, pop;
    sync_2ff #(.W(PW)) u_sync (.clk_out(clk_out), .arst(arst), .d(bus.address_w), .q(wsync));
    always_comb begin
        bus.dout_valid = count != 2'd0;
        bus.dout = buf0;
        pop = bus.dout_valid & bus.dout_ready;
        occ = {1'b0, count} + {2'b0, pend} - {2'b0, pop};
        bus.empty = wsync == bus.address_r;
        bus.r_en = !bus.empty && occ < 3'd2;
        rbin_nxt = rbin + {{DEEP{1'b0}}, bus.r_en};
        c1 = count - {1'b0, pop};
        bus.level = PW'(gray2bin(FN_W'(wsync))) - rbin;
    end
    // the word in flight lands in the first free slot after this cycle's pop
    always_ff @(posedge clk_out)
        if (arst) begin
            rbin <= '0;
            bus.address_r <= '0;
            pend <= 1'b0;
            count <= '0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            rbin <= rbin_nxt;
            bus.address_r <= PW'(bin2gray(FN_W'(rbin_nxt)));
            pend <= bus.r_en;
            count <= c1 + {1'b0, pend};
            buf0 <= pend && c1 == 2'd0 ? bus.data_o : pop ? buf1 : buf0;
            buf1 <= pend && c1 == 2'd1 ? bus.data_o : buf1;
        end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed checks of the read controller with DEEP=3, N=8
module tb_fifo_read_ctrl;
    localparam logic [3:0] GRAY [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                         4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic clk_out = 1'b0;
    logic arst = 1'b1;
    int checks = 0;
    int failures = 0;
    fifo_read_ctrl_if #(.N(8), .DEEP(3)) bus ();
    fifo_read_ctrl #(.N(8), .DEEP(3)) dut (.clk_out(clk_out), .arst(arst), .bus(bus));
    always #5 clk_out = ~clk_out;
    // memory model: word tagged with the Gray pointer it was read from
    always @(posedge clk_out) if (bus.r_en) bus.data_o <= {4'h5, bus.address_r};
    task automatic step();
        @(posedge clk_out);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        arst = 1'b1;
        bus.address_w = '0;
        step();
        step();
        arst = 1'b0;
    endtask
    initial begin
        bus.address_w = '0;
        bus.dout_ready = 1'b0;
        bus.data_o = '0;
        do_reset();
        chk("rst_empty", bus.empty, 1);
        chk("rst_r_en", bus.r_en, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_addr_r", bus.address_r, 0);
        chk("rst_dout", bus.dout, 0);
        step();
        step();
        chk("idle_r_en", bus.r_en, 0);
        // single word
        bus.address_w = GRAY[1];
        bus.dout_ready = 1'b1;
        step();
        chk("one_r_en_early", bus.r_en, 0);
        step();
        chk("one_r_en", bus.r_en, 1);
        chk("one_empty", bus.empty, 0);
        chk("one_level", bus.level, 1);
        step();
        chk("one_addr_r", bus.address_r, 1);
        chk("one_r_en_drop", bus.r_en, 0);
        chk("one_valid_early", bus.dout_valid, 0);
        step();
        chk("one_valid", bus.dout_valid, 1);
        chk("one_dout", bus.dout, {4'h5, GRAY[0]});
        step();
        chk("one_valid_after", bus.dout_valid, 0);
        chk("one_empty_after", bus.empty, 1);
        // five words streaming
        do_reset();
        bus.address_w = GRAY[5];
        bus.dout_ready = 1'b1;
        step();
        step();
        chk("burst_r_en", bus.r_en, 1);
        chk("burst_level", bus.level, 5);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("burst_valid%0d", k), bus.dout_valid, 1);
            chk($sformatf("burst_dout%0d", k), bus.dout, {4'h5, GRAY[k]});
            step();
        end
        chk("burst_valid_end", bus.dout_valid, 0);
        chk("burst_empty", bus.empty, 1);
        chk("burst_addr_r", bus.address_r, 7);
        chk("burst_r_en_end", bus.r_en, 0);
        // backpressure
        do_reset();
        bus.address_w = GRAY[5];
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("bp_r_en", bus.r_en, 0);
        chk("bp_level", bus.level, 3);
        chk("bp_addr_r", bus.address_r, 3);
        chk("bp_dout", bus.dout, {4'h5, GRAY[0]});
        step();
        chk("bp_r_en_hold", bus.r_en, 0);
        chk("bp_valid_hold", bus.dout_valid, 1);
        chk("bp_dout_hold", bus.dout, {4'h5, GRAY[0]});
        chk("bp_level_hold", bus.level, 3);
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_drain_valid%0d", k), bus.dout_valid, 1);
            chk($sformatf("bp_drain_dout%0d", k), bus.dout, {4'h5, GRAY[k]});
            step();
        end
        chk("bp_drain_end", bus.dout_valid, 0);
        chk("bp_empty", bus.empty, 1);
        // pointer wrap: advance rbin to 14, then write pointer to 2
        do_reset();
        bus.address_w = GRAY[14];
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("wrap_pre_addr_r", bus.address_r, 9);
        chk("wrap_pre_empty", bus.empty, 1);
        chk("wrap_pre_valid", bus.dout_valid, 0);
        bus.address_w = GRAY[2];
        step();
        step();
        chk("wrap_r_en", bus.r_en, 1);
        chk("wrap_level", bus.level, 4);
        step();
        chk("wrap_addr_r0", bus.address_r, 8);
        step();
        chk("wrap_addr_r1", bus.address_r, 0);
        chk("wrap_dout0", bus.dout, 8'h59);
        step();
        chk("wrap_addr_r2", bus.address_r, 1);
        chk("wrap_dout1", bus.dout, 8'h58);
        step();
        chk("wrap_addr_r3", bus.address_r, 3);
        chk("wrap_dout2", bus.dout, 8'h50);
        chk("wrap_empty", bus.empty, 1);
        step();
        chk("wrap_dout3", bus.dout, 8'h51);
        step();
        chk("wrap_valid_end", bus.dout_valid, 0);
        // reset with a word buffered and a read in flight
        do_reset();
        bus.address_w = GRAY[5];
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_valid_pre", bus.dout_valid, 1);
        arst = 1'b1;
        step();
        chk("mid_valid", bus.dout_valid, 0);
        chk("mid_r_en", bus.r_en, 0);
        chk("mid_addr_r", bus.address_r, 0);
        chk("mid_level", bus.level, 0);
        chk("mid_empty", bus.empty, 1);
        arst = 1'b0;
        bus.address_w = '0;
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mid_stale_valid%0d", k), bus.dout_valid, 0);
            chk($sformatf("mid_stale_r_en%0d", k), bus.r_en, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
